// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between two requesters (M0 video
// writer, M1 readback/debug). Round-robin with a per-grant burst cap, one
// idle cycle on every grant change. All BRAM-side signals are registered.
// Read data is tagged through a 2-stage pipeline so each RdValid only fires
// for the requester that issued the read.
module bram_port_arbiter #(
  parameter int C_AWIDTH    = 32,
  parameter int C_DWIDTH    = 32,
  parameter int C_MAX_BURST = 16
) (
  input  logic                    BRAM_Clk,
  input  logic                    BRAM_Rst,
  input  logic                    M0_Req,
  input  logic                    M0_RNW,
  input  logic [0:C_DWIDTH/8-1]   M0_BE,
  input  logic [0:C_AWIDTH-1]     M0_Addr,
  input  logic [0:C_DWIDTH-1]     M0_WrData,
  output logic                    M0_Ack,
  output logic [0:C_DWIDTH-1]     M0_RdData,
  output logic                    M0_RdValid,
  input  logic                    M1_Req,
  input  logic                    M1_RNW,
  input  logic [0:C_DWIDTH/8-1]   M1_BE,
  input  logic [0:C_AWIDTH-1]     M1_Addr,
  input  logic [0:C_DWIDTH-1]     M1_WrData,
  output logic                    M1_Ack,
  output logic [0:C_DWIDTH-1]     M1_RdData,
  output logic                    M1_RdValid,
  output logic                    BRAM_EN,
  output logic [0:C_DWIDTH/8-1]   BRAM_WEN,
  output logic [0:C_AWIDTH-1]     BRAM_Addr,
  output logic [0:C_DWIDTH-1]     BRAM_Dout,
  input  logic [0:C_DWIDTH-1]     BRAM_Din
);

  localparam int C_BEW = C_DWIDTH / 8;
  localparam int C_CW  = $clog2(C_MAX_BURST + 1);
  localparam logic [C_CW-1:0] C_CAP = C_CW'(C_MAX_BURST);
  localparam logic [C_CW-1:0] C_ONE = C_CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [C_CW-1:0]   count_r;
  logic [C_CW-1:0]   next_count_s;
  logic [C_CW-1:0]   count_inc_s;
  logic              last_owner_r;
  logic              next_last_owner_s;

  logic              xfer_s;
  logic              xfer_id_s;
  logic              xfer_rnw_s;
  logic [0:C_BEW-1]  xfer_be_s;
  logic [0:C_AWIDTH-1] xfer_addr_s;
  logic [0:C_DWIDTH-1] xfer_data_s;

  logic              tag1_valid_r;
  logic              tag1_id_r;
  logic              tag2_valid_r;
  logic              tag2_id_r;

  // Acks are withheld in IDLE and while reset is asserted; only the owner can be acked.
  assign M0_Ack = M0_Req & (state_r == OWN0) & ~BRAM_Rst;
  assign M1_Ack = M1_Req & (state_r == OWN1) & ~BRAM_Rst;

  // The BRAM read data is broadcast; RdValid tells each side whether it is theirs.
  assign M0_RdData  = BRAM_Din;
  assign M1_RdData  = BRAM_Din;
  assign M0_RdValid = tag2_valid_r & ~tag2_id_r;
  assign M1_RdValid = tag2_valid_r & tag2_id_r;

  // Select the request fields of whichever side is transferring this cycle.
  always_comb begin
    xfer_s      = M0_Ack | M1_Ack;
    xfer_id_s   = M1_Ack;
    if (M1_Ack) begin
      xfer_rnw_s  = M1_RNW;
      xfer_be_s   = M1_BE;
      xfer_addr_s = M1_Addr;
      xfer_data_s = M1_WrData;
    end else begin
      xfer_rnw_s  = M0_RNW;
      xfer_be_s   = M0_BE;
      xfer_addr_s = M0_Addr;
      xfer_data_s = M0_WrData;
    end
  end

  // Arbitration: pick an owner from IDLE, count owner transfers, release on drop or cap.
  always_comb begin
    next_state_s      = state_r;
    next_count_s      = count_r;
    next_last_owner_s = last_owner_r;
    if (count_r == C_CAP) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + C_ONE;
    end
    case (state_r)
      IDLE: begin
        if (M0_Req && M1_Req) begin
          if (last_owner_r) begin
            next_state_s      = OWN0;
            next_last_owner_s = 1'b0;
          end else begin
            next_state_s      = OWN1;
            next_last_owner_s = 1'b1;
          end
          next_count_s = '0;
        end else if (M0_Req) begin
          next_state_s      = OWN0;
          next_last_owner_s = 1'b0;
          next_count_s      = '0;
        end else if (M1_Req) begin
          next_state_s      = OWN1;
          next_last_owner_s = 1'b1;
          next_count_s      = '0;
        end else begin
          next_state_s = IDLE;
        end
      end
      OWN0: begin
        if (!M0_Req) begin
          next_state_s = IDLE;
        end else begin
          // A transfer happens this cycle; the cap test includes it.
          next_count_s = count_inc_s;
          if ((count_inc_s == C_CAP) && M1_Req) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = OWN0;
          end
        end
      end
      OWN1: begin
        if (!M1_Req) begin
          next_state_s = IDLE;
        end else begin
          next_count_s = count_inc_s;
          if ((count_inc_s == C_CAP) && M0_Req) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = OWN1;
          end
        end
      end
      default: begin
        next_state_s = IDLE;
        next_count_s = '0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      state_r      <= IDLE;
      count_r      <= '0;
      last_owner_r <= 1'b1;
    end else begin
      state_r      <= next_state_s;
      count_r      <= next_count_s;
      last_owner_r <= next_last_owner_s;
    end
  end

  // Register the BRAM port; Addr and Dout hold their last value on idle cycles.
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      BRAM_EN   <= 1'b0;
      BRAM_WEN  <= '0;
      BRAM_Addr <= '0;
      BRAM_Dout <= '0;
    end else if (xfer_s) begin
      BRAM_EN   <= 1'b1;
      BRAM_WEN  <= xfer_rnw_s ? {C_BEW{1'b0}} : xfer_be_s;
      BRAM_Addr <= xfer_addr_s;
      BRAM_Dout <= xfer_data_s;
    end else begin
      BRAM_EN   <= 1'b0;
      BRAM_WEN  <= '0;
    end
  end

  // Read tag pipeline: stage 1 tracks the BRAM access cycle, stage 2 the data-return cycle.
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      tag1_valid_r <= 1'b0;
      tag1_id_r    <= 1'b0;
      tag2_valid_r <= 1'b0;
      tag2_id_r    <= 1'b0;
    end else begin
      tag1_valid_r <= xfer_s & xfer_rnw_s;
      tag1_id_r    <= xfer_id_s;
      tag2_valid_r <= tag1_valid_r;
      tag2_id_r    <= tag1_id_r;
    end
  end

endmodule
